// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared op and state encodings for the iterative divider
package div_unit_pkg;

    // Operation encodings, matching funct3[1:0] of the RV32M divide group
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // DIV and REM treat their operands as two's complement
    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM and REMU return the remainder rather than the quotient
    function automatic logic op_is_rem(input logic [1:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV/DIVU/REM/REMU
module div_unit
    import div_unit_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         flush,
    output logic         busy,
    output logic         done,
    output logic [n-1:0] result
);

    localparam int CW = $clog2(n);
    localparam logic [n-1:0] SMIN = {1'b1, {(n-1){1'b0}}};

    state_t          state, state_nx;
    logic            rem_op_q;
    logic            q_neg_q;
    logic            r_neg_q;
    logic [n-1:0]    divisor_q;
    logic [n-1:0]    dvd_q;      // dividend shifts out the top, quotient bits shift in at the bottom
    logic [n-1:0]    rem_q;
    logic [CW-1:0]   count_q;

    // Operand decode at the accept point
    logic            is_signed, is_rem;
    logic            a_neg, b_neg;
    logic [n-1:0]    a_mag, b_mag;
    logic            div_zero, div_ovf, special;
    logic [n-1:0]    special_result;
    logic            accept;

    assign is_signed = op_is_signed(op);
    assign is_rem    = op_is_rem(op);
    assign a_neg     = is_signed & a[n-1];
    assign b_neg     = is_signed & b[n-1];
    assign a_mag     = a_neg ? (~a) + n'(1) : a;
    assign b_mag     = b_neg ? (~b) + n'(1) : b;
    assign div_zero  = (b == '0);
    assign div_ovf   = is_signed && (a == SMIN) && (b == '1);
    assign special   = div_zero | div_ovf;
    assign accept    = (state == S_IDLE) && start && !flush;

    // Zero divisor: quotient all ones, remainder is the raw dividend.
    // Signed overflow: quotient is the most negative value, remainder zero.
    assign special_result = div_zero ? (is_rem ? a : '1)
                                     : (is_rem ? '0 : SMIN);

    // One restoring step. The shifted partial remainder keeps n+1 bits so a
    // divisor with its top bit set is still compared correctly.
    logic [n:0]      shifted, trial;
    logic            q_bit;
    logic [n-1:0]    rem_step, dvd_step;
    logic [n-1:0]    q_fin, r_fin, calc_result;

    assign shifted  = {rem_q, dvd_q[n-1]};
    assign trial    = shifted - {1'b0, divisor_q};
    assign q_bit    = ~trial[n];
    assign rem_step = q_bit ? trial[n-1:0] : shifted[n-1:0];
    assign dvd_step = {dvd_q[n-2:0], q_bit};

    assign q_fin       = q_neg_q ? (~dvd_step) + n'(1) : dvd_step;
    assign r_fin       = r_neg_q ? (~rem_step) + n'(1) : rem_step;
    assign calc_result = rem_op_q ? r_fin : q_fin;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; flush overrides everything and returns to IDLE
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = special ? S_DONE : S_CALC;
            S_CALC: if (count_q == '0) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
        if (flush) state_nx = S_IDLE;
    end

    // Registered status outputs, derived from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nx != S_IDLE);
            done <= (state_nx == S_DONE);
        end
    end

    // Operand capture, iteration datapath and result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_op_q  <= 1'b0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            divisor_q <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            result    <= '0;
        end else if (accept) begin
            rem_op_q  <= is_rem;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            divisor_q <= b_mag;
            dvd_q     <= a_mag;
            rem_q     <= '0;
            count_q   <= CW'(n - 1);
            if (special) result <= special_result;
        end else if (state == S_CALC && !flush) begin
            dvd_q   <= dvd_step;
            rem_q   <= rem_step;
            count_q <= count_q - CW'(1);
            if (count_q == '0) result <= calc_result;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking bench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        flush;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    div_unit #(.n(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        if (y == 0) return 1'b1;
        return (o[0] == 1'b0) && (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    endfunction

    // Reference: plain SV arithmetic; signed / and % truncate toward zero
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx, sy;
        sx = x;
        sy = y;
        if (y == 0) return (o == 2'b10 || o == 2'b11) ? x : 32'hFFFF_FFFF;
        if (is_special(o, x, y)) return (o == 2'b10) ? 32'h0 : 32'h8000_0000;
        case (o)
            2'b00:   return sx / sy;
            2'b01:   return x / y;
            2'b10:   return sx % sy;
            default: return x % y;
        endcase
    endfunction

    // Issue one op and watch 40 cycles. Cycle c is the period after the
    // c-th rising edge following the start edge; outputs sampled at negedge.
    task automatic run(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       input int inj_c, input int flush_c,
                       output int done_c, output int done_cnt, output int busy_cnt,
                       output logic [31:0] res_o);
        @(negedge clk);
        op = op_i; a = a_i; b = b_i; start = 1'b1; flush = 1'b0;
        done_c = -1; done_cnt = 0; busy_cnt = 0; res_o = result;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_c < 0) begin
                    done_c = c;
                    res_o  = result;
                end
            end
            if (busy) busy_cnt++;
            start = (c == inj_c);
            flush = (c == flush_c);
            op = 2'($urandom);
            a  = $urandom;
            b  = $urandom;
        end
        start = 1'b0;
        flush = 1'b0;
    endtask

    task automatic full_check(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int dc, dn, bc;
        logic [31:0] r;
        bit sp;
        sp = is_special(o, x, y);
        run(o, x, y, 0, 0, dc, dn, bc, r);
        check({tag, "_result"}, r, model(o, x, y));
        check({tag, "_done_cycle"}, 32'(dc), sp ? 32'd1 : 32'd33);
        check({tag, "_busy_cycles"}, 32'(bc), sp ? 32'd1 : 32'd33);
        check({tag, "_done_pulses"}, 32'(dn), 32'd1);
        check({tag, "_held"}, result, model(o, x, y));
    endtask

    initial begin
        int dc, dn, bc;
        logic [31:0] r, prev;
        logic [1:0] ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        rst_n = 1'b1;

        full_check("divu_100_7", 2'b01, 32'd100, 32'd7);
        full_check("remu_100_7", 2'b11, 32'd100, 32'd7);
        full_check("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2);
        full_check("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2);
        full_check("div_5_0",    2'b00, 32'd5, 32'd0);
        full_check("remu_5_0",   2'b11, 32'd5, 32'd0);
        full_check("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
        full_check("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        full_check("divu_big",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        full_check("remu_big",   2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

        // Flush in cycle 10: no done, busy drops in cycle 11, result unchanged
        prev = result;
        run(2'b01, 32'd1000, 32'd3, 0, 10, dc, dn, bc, r);
        check("flush_done_pulses", 32'(dn), 32'd0);
        check("flush_busy_cycles", 32'(bc), 32'd10);
        check("flush_result_kept", result, prev);

        // Start while busy in cycle 5 is ignored
        run(2'b01, 32'd100, 32'd7, 5, 0, dc, dn, bc, r);
        check("ignored_start_result", r, 32'd14);
        check("ignored_start_cycle", 32'(dc), 32'd33);
        check("ignored_start_pulses", 32'(dn), 32'd1);

        // Asynchronous reset in cycle 15 of CALC
        @(negedge clk);
        op = 2'b01; a = 32'd77; b = 32'd5; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", {31'b0, busy}, 32'd0);
        check("async_rst_done", {31'b0, done}, 32'd0);
        check("async_rst_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        full_check("divu_9_3_after_rst", 2'b01, 32'd9, 32'd3);

        // Randomized ops with biased divisors
        for (int i = 0; i < 30; i++) begin
            ro = 2'($urandom);
            ra = $urandom;
            case ($urandom_range(0, 4))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 15);
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            full_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
